// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, synchronous imem addressing and IF/ID latch.
// Optional performance counters enabled by defining FETCH_PERF_COUNTERS_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [7:0]  imem_address,
  input  logic [31:0] imem_q,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic        ifid_valid
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  localparam logic [31:0] PC_STEP    = 32'd4;
  localparam logic [7:0]  RESET_WORD = RESET_PC[9:2];

  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] ifid_pc_next;
  logic        ifid_valid_next;
  logic        load;
  logic        hold;

  // Instruction data comes straight from the memory; a stall re-reads the held word.
  assign ifid_instr = imem_q;

  // Next-state selection: redirect beats stall, stall holds, otherwise advance.
  always_comb begin
    pc_next         = pc;
    ifid_pc_next    = ifid_pc;
    ifid_valid_next = ifid_valid;
    load            = 1'b0;
    hold            = 1'b0;
    if (redirect_valid) begin
      pc_next         = redirect_pc + PC_STEP;
      ifid_pc_next    = redirect_pc;
      ifid_valid_next = 1'b1;
      load            = 1'b1;
    end else if (stall) begin
      hold            = 1'b1;
    end else begin
      pc_next         = pc + PC_STEP;
      ifid_pc_next    = pc;
      ifid_valid_next = 1'b1;
      load            = 1'b1;
    end
  end

  // Word address for the synchronous memory, same priority as the state update.
  always_comb begin
    imem_address = pc[9:2];
    if (reset) begin
      imem_address = RESET_WORD;
    end else if (redirect_valid) begin
      imem_address = redirect_pc[9:2];
    end else if (stall) begin
      imem_address = ifid_pc[9:2];
    end
  end

  // PC and IF/ID registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc         <= RESET_PC;
      ifid_pc    <= RESET_PC;
      ifid_valid <= 1'b0;
    end else begin
      pc         <= pc_next;
      ifid_pc    <= ifid_pc_next;
      ifid_valid <= ifid_valid_next;
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  // Fetch and stall event counters, wrapping at 2^32.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_count <= 32'd0;
      stall_count <= 32'd0;
    end else begin
      if (load) fetch_count <= fetch_count + 32'd1;
      if (hold) stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with a scoreboard of expected IF/ID contents.
// Define FETCH_PERF_COUNTERS_EN to also check the performance counters.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [7:0]  imem_address;
  logic [31:0] imem_q;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic        ifid_valid;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] m_pc;
  logic [31:0] m_ifid_pc;
  logic        m_valid;
  logic [31:0] m_fetch;
  logic [31:0] m_stall;

  fetch_unit dut (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_address   (imem_address),
    .imem_q         (imem_q),
    .ifid_instr     (ifid_instr),
    .ifid_pc        (ifid_pc),
    .ifid_valid     (ifid_valid)
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    .fetch_count    (fetch_count),
    .stall_count    (stall_count)
`endif
  );

  always #5 clock = ~clock;

  // Synchronous instruction memory: word k holds 0x1000_0000 + k.
  always @(posedge clock) imem_q <= 32'h1000_0000 + {24'h0, imem_address};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] word_of(input logic [31:0] a);
    logic [7:0] w;
    w = a[9:2];
    return 32'h1000_0000 + {24'h0, w};
  endfunction

  // One clock with given inputs; checks address now and IF/ID after the edge.
  task automatic cycle(input logic s, input logic rv, input logic [31:0] rp);
    exp_t        e;
    logic [7:0]  ea;
    logic [31:0] t;
    stall          = s;
    redirect_valid = rv;
    redirect_pc    = rp;
    #1;
    if (rv)     begin t = rp;        ea = t[9:2]; end
    else if (s) begin t = m_ifid_pc; ea = t[9:2]; end
    else        begin t = m_pc;      ea = t[9:2]; end
    total++;
    if (imem_address !== ea) begin
      bad++;
      $display("FAIL imem_address: got %h want %h", imem_address, ea);
    end
    if (rv) begin
      m_ifid_pc = rp; m_pc = rp + 32'd4; m_valid = 1'b1; m_fetch = m_fetch + 32'd1;
    end else if (s) begin
      m_stall = m_stall + 32'd1;
    end else begin
      m_ifid_pc = m_pc; m_pc = m_pc + 32'd4; m_valid = 1'b1; m_fetch = m_fetch + 32'd1;
    end
    e.pc = m_ifid_pc; e.instr = word_of(m_ifid_pc); e.valid = m_valid;
    sb.push_back(e);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    total++;
    if (ifid_pc !== e.pc) begin
      bad++; $display("FAIL ifid_pc: got %h want %h", ifid_pc, e.pc);
    end
    total++;
    if (ifid_instr !== e.instr) begin
      bad++; $display("FAIL ifid_instr: got %h want %h", ifid_instr, e.instr);
    end
    total++;
    if (ifid_valid !== e.valid) begin
      bad++; $display("FAIL ifid_valid: got %b want %b", ifid_valid, e.valid);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_ifid_pc = 32'h0; m_valid = 1'b0; m_fetch = 32'h0; m_stall = 32'h0;
    sb.delete();
  endtask

  task automatic check_reset_state(input string tag);
    total++;
    if (ifid_valid !== 1'b0) begin
      bad++; $display("FAIL %s ifid_valid: got %b want 0", tag, ifid_valid);
    end
    total++;
    if (ifid_pc !== 32'h0) begin
      bad++; $display("FAIL %s ifid_pc: got %h want 00000000", tag, ifid_pc);
    end
    total++;
    if (imem_address !== 8'h00) begin
      bad++; $display("FAIL %s imem_address: got %h want 00", tag, imem_address);
    end
`ifdef FETCH_PERF_COUNTERS_EN
    total++;
    if (fetch_count !== 32'h0 || stall_count !== 32'h0) begin
      bad++; $display("FAIL %s counters: got %0d/%0d want 0/0", tag, fetch_count, stall_count);
    end
`endif
  endtask

  // Reset holds state even with stall/redirect asserted; release at posedge+1.
  task automatic test_reset();
    reset = 1'b1; stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
    repeat (3) @(posedge clock);
    #1;
    check_reset_state("reset");
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_sequential();
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b0, 32'h0);
      total++;
      if (ifid_pc !== 32'(k * 4) || ifid_instr !== 32'h1000_0000 + 32'(k)) begin
        bad++;
        $display("FAIL seq%0d: got pc %h instr %h want pc %h instr %h",
                 k, ifid_pc, ifid_instr, 32'(k * 4), 32'h1000_0000 + 32'(k));
      end
    end
  endtask

  task automatic test_stall();
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b0, 32'h0);
      total++;
      if (ifid_pc !== 32'h8 || ifid_instr !== 32'h1000_0002) begin
        bad++; $display("FAIL stall%0d: got pc %h instr %h want pc 8 instr 10000002", k, ifid_pc, ifid_instr);
      end
    end
    cycle(1'b0, 1'b0, 32'h0);
    total++;
    if (ifid_pc !== 32'hC) begin
      bad++; $display("FAIL stall_release: got %h want 0000000c", ifid_pc);
    end
  endtask

  task automatic test_redirect();
    cycle(1'b0, 1'b1, 32'h40);
    total++;
    if (ifid_pc !== 32'h40 || ifid_instr !== 32'h1000_0010) begin
      bad++; $display("FAIL redirect: got pc %h instr %h want 40/10000010", ifid_pc, ifid_instr);
    end
    cycle(1'b0, 1'b0, 32'h0);
    total++;
    if (ifid_pc !== 32'h44) begin
      bad++; $display("FAIL redirect_next: got %h want 00000044", ifid_pc);
    end
  endtask

  task automatic test_redirect_stall();
    cycle(1'b1, 1'b1, 32'h20);
    total++;
    if (ifid_pc !== 32'h20) begin
      bad++; $display("FAIL redirect_over_stall: got %h want 00000020", ifid_pc);
    end
    cycle(1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_wrap();
    cycle(1'b0, 1'b1, 32'h3FC);
    cycle(1'b0, 1'b0, 32'h0);
    total++;
    if (ifid_pc !== 32'h400 || ifid_instr !== 32'h1000_0000) begin
      bad++; $display("FAIL addr_wrap: got pc %h instr %h want 400/10000000", ifid_pc, ifid_instr);
    end
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC);
    cycle(1'b0, 1'b0, 32'h0);
    total++;
    if (ifid_pc !== 32'h0) begin
      bad++; $display("FAIL pc_wrap: got %h want 00000000", ifid_pc);
    end
  endtask

  task automatic test_back_to_back();
    cycle(1'b0, 1'b1, 32'h42);
    cycle(1'b0, 1'b1, 32'h100);
    cycle(1'b1, 1'b1, 32'h204);
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    total++;
    if (ifid_pc !== 32'h208) begin
      bad++; $display("FAIL back_to_back: got %h want 00000208", ifid_pc);
    end
    for (int k = 0; k < 20; k++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), $urandom);
  endtask

  // Assert reset between edges during a stall and check it acts at once.
  task automatic test_async_reset();
    cycle(1'b0, 1'b0, 32'h0);
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
    #2;
    reset = 1'b1;
    #1;
    check_reset_state("async_reset");
    @(posedge clock);
    #1;
    stall = 1'b0; redirect_valid = 1'b0;
    reset = 1'b0;
    model_reset();
    cycle(1'b0, 1'b0, 32'h0);
  endtask

`ifdef FETCH_PERF_COUNTERS_EN
  task automatic test_counters();
    reset = 1'b1;
    #1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 2; k++) cycle(1'b1, 1'b0, 32'h0);
    total++;
    if (fetch_count !== 32'd5 || m_fetch !== 32'd5) begin
      bad++; $display("FAIL fetch_count: got %0d want 5", fetch_count);
    end
    total++;
    if (stall_count !== 32'd2 || m_stall !== 32'd2) begin
      bad++; $display("FAIL stall_count: got %0d want 2", stall_count);
    end
    test_async_reset();
    total++;
    if (fetch_count !== m_fetch || stall_count !== m_stall) begin
      bad++; $display("FAIL counters_after_reset: got %0d/%0d want %0d/%0d",
                      fetch_count, stall_count, m_fetch, m_stall);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_wrap();
    test_back_to_back();
    test_async_reset();
`ifdef FETCH_PERF_COUNTERS_EN
    test_counters();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
